// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter signals shared by the scheduler and its environment.
// master = the scheduler itself, slave = the requesters plus the uart transmitter.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 busy;
  logic                 frame_done;
  logic                 abort;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ack, grant, tx_start, tx_data, busy, frame_done, abort
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ack, grant, tx_start, tx_data, busy, frame_done, abort
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Frame-granular round-robin sharing of one uart transmitter between NUM_REQ byte streams.
// Every frame is preceded by a header byte HDR_BASE+index so the far end can demultiplex.
module uart_tx_scheduler #(
  parameter int         NUM_REQ      = 2,
  parameter logic [7:0] HDR_BASE     = 8'hA0,
  parameter int         IDLE_TIMEOUT = 1023
) (
  input logic               clk,
  input logic               reset,
  uart_tx_scheduler_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR_GO  = 3'd1;
  localparam logic [2:0] S_HDR_WLO = 3'd2;
  localparam logic [2:0] S_HDR_WHI = 3'd3;
  localparam logic [2:0] S_DAT_GO  = 3'd4;
  localparam logic [2:0] S_DAT_WLO = 3'd5;
  localparam logic [2:0] S_DAT_WHI = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               abort_q, abort_d;

  logic [IW-1:0]      win, rr_inc;
  logic               win_vld;
  logic               start_c;
  logic [NUM_REQ-1:0] ack_c;
  logic               cur_valid, cur_last;
  logic [7:0]         cur_byte;

  assign cur_valid = bus.req_valid[idx_q];
  assign cur_last  = bus.req_last[idx_q];
  assign cur_byte  = bus.req_data[{idx_q, 3'b000} +: 8];
  assign rr_inc    = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

  // First requesting index at or after the rr pointer, wrapping around.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && bus.req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        win_vld = 1'b1;
        win     = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    abort_d   = 1'b0;
    start_c   = 1'b0;
    ack_c     = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld && bus.tx_ready) begin
          idx_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          tx_data_d    = HDR_BASE + 8'(win);
          state_d      = S_HDR_GO;
        end
      end
      S_HDR_GO: begin
        if (bus.tx_ready) begin
          start_c = 1'b1;
          state_d = S_HDR_WLO;
        end
      end
      // The transmitter still shows ready for one cycle after a start; only a fall counts.
      S_HDR_WLO: if (!bus.tx_ready) state_d = S_HDR_WHI;
      S_HDR_WHI: begin
        if (bus.tx_ready) begin
          cnt_d   = '0;
          state_d = S_DAT_GO;
        end
      end
      S_DAT_GO: begin
        if (cur_valid && bus.tx_ready) begin
          start_c      = 1'b1;
          ack_c[idx_q] = 1'b1;
          tx_data_d    = cur_byte;
          last_d       = cur_last;
          cnt_d        = '0;
          state_d      = S_DAT_WLO;
        end else if (cnt_q == CW'(IDLE_TIMEOUT)) begin
          abort_d = 1'b1;
          rr_d    = rr_inc;
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DAT_WLO: if (!bus.tx_ready) state_d = S_DAT_WHI;
      S_DAT_WHI: begin
        if (bus.tx_ready) begin
          cnt_d   = '0;
          state_d = last_q ? S_DONE : S_DAT_GO;
        end
      end
      S_DONE: begin
        rr_d    = rr_inc;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
    end
  end

  // Data bytes go out in the ack cycle, so the live requester byte is shown in DAT_GO.
  assign bus.tx_data    = (state_q == S_DAT_GO) ? cur_byte : tx_data_q;
  assign bus.tx_start   = start_c & ~reset;
  assign bus.req_ack    = ack_c & {NUM_REQ{~reset}};
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.abort      = abort_q;

  a_start_when_ready: assert property (@(posedge clk) disable iff (reset)
    bus.tx_start |-> bus.tx_ready);
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant_q));
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues, a simple transmitter model,
// and a per-cycle checker that derives expected outputs from the arbitration/framing rules.
module tb_uart_tx_scheduler;
  localparam int         N   = 2;
  localparam int         TO  = 40;
  localparam int         SYM = 22;
  localparam logic [7:0] HB  = 8'hA0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N)) bus ();

  uart_tx_scheduler #(.NUM_REQ(N), .HDR_BASE(HB), .IDLE_TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         total = 0;
  int         bad   = 0;
  logic [8:0] rq [N][$];
  logic [N-1:0] en = '0;
  logic [7:0] txlog [$];
  int         n_fd = 0;
  int         n_ab = 0;
  int         n_ack [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int j);
    logic [N-1:0] r;
    r = '0;
    if (j >= 0) r[j] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Requesters present queue heads; the transmitter holds ready one cycle after start,
  // then drops it for SYM cycles.
  initial begin : drv
    logic [N-1:0] ack_s;
    logic st_s;
    int dly, bcnt;
    dly = 0; bcnt = 0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      ack_s = bus.req_ack;
      st_s  = bus.tx_start;
      @(posedge clk); #1;
      if (reset) begin
        dly = 0; bcnt = 0; bus.tx_ready = 1'b1;
      end else if (st_s) begin
        dly = 1; bcnt = SYM;
      end else if (dly == 1) begin
        dly = 0; bus.tx_ready = 1'b0;
      end else if (bcnt > 0) begin
        bcnt--; bus.tx_ready = (bcnt == 0);
      end
      for (int i = 0; i < N; i++)
        if (ack_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < N; i++) begin
        if (en[i] && rq[i].size() > 0) begin
          bus.req_valid[i]       = 1'b1;
          bus.req_data[i*8 +: 8] = rq[i][0][7:0];
          bus.req_last[i]        = rq[i][0][8];
        end else begin
          bus.req_valid[i]       = 1'b0;
          bus.req_data[i*8 +: 8] = 8'h00;
          bus.req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin : mon
    logic [N-1:0] pg, pv, g;
    logic [7:0] hd, ex;
    logic slo, shi, hold, plast, efd;
    int owner, m_rr, nst;
    pg = '0; pv = '0; owner = 0; m_rr = 0; nst = 0;
    slo = 1; shi = 1; hold = 0; plast = 0; efd = 0; hd = '0;
    for (int i = 0; i < N; i++) n_ack[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pg = '0; pv = '0; m_rr = 0; nst = 0;
        slo = 1; shi = 1; hold = 0; plast = 0; efd = 0;
      end else begin
        g = bus.grant;
        check("busy", bus.busy, |g);
        if (g != '0 && pg != '0) check("lock", g, pg);
        if (g != '0 && pg == '0) begin
          check("arb", g, onehot(pick(pv, m_rr)));
          owner = idx_of(g);
          nst   = 0;
        end
        check("fdone", bus.frame_done, efd);
        efd = 0;
        if (bus.tx_start) begin
          check("start_rdy", bus.tx_ready, 1);
          check("start_seq", slo && shi, 1);
          ex = (nst == 0) ? 8'(HB + owner) : bus.req_data[owner*8 +: 8];
          check("txdata", bus.tx_data, ex);
          check("ack", bus.req_ack, (nst == 0) ? {N{1'b0}} : g);
          if (nst != 0) plast = bus.req_last[owner];
          nst++;
          txlog.push_back(bus.tx_data);
          slo = 0; shi = 0; hold = 1; hd = bus.tx_data;
        end else begin
          check("ack_idle", bus.req_ack, 0);
          if (hold) check("hold", bus.tx_data, hd);
          if (!bus.tx_ready) slo = 1;
          else if (slo) shi = 1;
          if (hold && shi) begin
            hold = 0; efd = plast; plast = 0;
          end
        end
        for (int i = 0; i < N; i++) if (bus.req_ack[i]) n_ack[i]++;
        if (bus.frame_done) begin
          n_fd++; m_rr = (owner + 1) % N;
        end
        if (bus.abort) begin
          n_ab++;
          check("abort_gnt", g, 0);
          m_rr = (owner + 1) % N;
        end
        pg = g;
        pv = bus.req_valid;
      end
    end
  end

  task automatic wait_fd(input int tgt, input int maxc);
    int c;
    c = 0;
    while (n_fd < tgt && c < maxc) begin @(negedge clk); c++; end
    check("wait_fd", n_fd >= tgt, 1);
  endtask

  task automatic wait_gz(input int maxc);
    int c;
    c = 0;
    while (bus.grant != '0 && c < maxc) begin @(negedge clk); c++; end
    check("wait_gz", bus.grant, 0);
  endtask

  task automatic wait_gnz(input int maxc);
    int c;
    c = 0;
    while (bus.grant == '0 && c < maxc) begin @(negedge clk); c++; end
    check("wait_gnz", bus.grant != '0, 1);
  endtask

  task automatic check_log(input string nm, input int n, input logic [63:0] bytes);
    check({nm, "_len"}, txlog.size(), n);
    for (int i = 0; i < n; i++)
      if (i < txlog.size())
        check($sformatf("%s_b%0d", nm, i), txlog[i], bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : tst
    int c, fd0, ab0, a0;
    repeat (3) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_start", bus.tx_start, 0);
    check("rst_ack", bus.req_ack, 0);
    check("rst_fd", bus.frame_done, 0);
    check("rst_abort", bus.abort, 0);
    check("rst_txdata", bus.tx_data, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_grant", bus.grant, 0);
    check("idle_busy", bus.busy, 0);

    // two-byte frame from requester 0
    txlog.delete();
    rq[0].push_back({1'b0, 8'h11}); rq[0].push_back({1'b1, 8'h22});
    en = 2'b01;
    wait_fd(1, 400);
    repeat (3) @(negedge clk);
    check_log("t1", 3, 64'hA01122);
    check("t1_acks", n_ack[0], 2);
    check("t1_fd", n_fd, 1);
    check("t1_busy", bus.busy, 0);

    // both requesting from reset: rr alternates single-byte frames
    do_reset();
    txlog.delete();
    fd0 = n_fd;
    rq[0].push_back({1'b1, 8'h31}); rq[0].push_back({1'b1, 8'h33});
    rq[1].push_back({1'b1, 8'h32});
    en = 2'b11;
    wait_fd(fd0 + 3, 600);
    repeat (3) @(negedge clk);
    check_log("t2", 6, 64'hA031A132A033);

    // requester 1 arrives mid-frame and must wait for frame_done
    txlog.delete();
    fd0 = n_fd; a0 = n_ack[0];
    rq[0].push_back({1'b0, 8'h41}); rq[0].push_back({1'b0, 8'h42});
    rq[0].push_back({1'b1, 8'h43});
    en = 2'b01;
    c = 0;
    while (n_ack[0] < a0 + 1 && c < 200) begin @(negedge clk); c++; end
    rq[1].push_back({1'b1, 8'h51});
    en = 2'b11;
    repeat (5) @(negedge clk);
    check("t3_lock", bus.grant, 2'b01);
    wait_fd(fd0 + 1, 400);
    wait_gz(10);
    wait_gnz(10);
    check("t3_next", bus.grant, 2'b10);
    wait_fd(fd0 + 2, 400);
    repeat (3) @(negedge clk);
    check_log("t3", 6, 64'hA0414243A151);

    // requester 0 goes quiet after the header: timeout abort, rr moves on
    txlog.delete();
    ab0 = n_ab;
    rq[0].push_back({1'b0, 8'h61});
    en = 2'b01;
    wait_gnz(50);
    en = 2'b00;
    c = 0;
    while (bus.tx_ready && c < 50) begin @(negedge clk); c++; end
    c = 0;
    while (!bus.tx_ready && c < 100) begin @(negedge clk); c++; end
    // TO+1 idle DAT_GO cycles follow the header symbol, the abort lands in the next IDLE cycle
    c = 0;
    while (!bus.abort && c < TO + 20) begin @(negedge clk); c++; end
    check("t4_lat", c, TO + 2);
    check("t4_gnt", bus.grant, 0);
    @(negedge clk);
    check("t4_pulse", bus.abort, 0);
    check("t4_cnt", n_ab, ab0 + 1);
    check_log("t4", 1, 64'hA0);
    rq[0].delete();
    txlog.delete();
    fd0 = n_fd;
    rq[0].push_back({1'b1, 8'h71}); rq[1].push_back({1'b1, 8'h72});
    en = 2'b11;
    wait_fd(fd0 + 2, 600);
    repeat (3) @(negedge clk);
    check_log("t4rr", 4, 64'hA172A071);

    // reset while a data byte is on the wire
    en = 2'b10;
    rq[1].push_back({1'b1, 8'h81});
    c = 0;
    while (!bus.req_ack[1] && c < 200) begin @(negedge clk); c++; end
    check("t6_ack", bus.req_ack, 2'b10);
    c = 0;
    while (bus.tx_ready && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    check("t6_inbyte", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_grant", bus.grant, 0);
    check("t6_start", bus.tx_start, 0);
    check("t6_busy", bus.busy, 0);
    reset = 1'b0;
    rq[0].delete(); rq[1].delete();
    txlog.delete();
    fd0 = n_fd;
    rq[0].push_back({1'b1, 8'h91}); rq[1].push_back({1'b1, 8'h92});
    en = 2'b11;
    wait_fd(fd0 + 2, 600);
    repeat (5) @(negedge clk);
    check_log("t6", 4, 64'hA091A192);
    check("end_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
